display_line_fetch: RTL and testbench



---
 rtl/display_pkg.sv | 15 +
 rtl/display_line_fetch.sv | 126 ++++++++++++
 tb/tb_display_line_fetch.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared 1080p timing constants and the line-fetch FSM state type.
package display_pkg;

  localparam int H_RES        = 1920;
  localparam int V_RES        = 1080;
  localparam int V_LAST       = 1124;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/display_line_fetch.sv
// Fetches the next active video line from the framebuffer during horizontal
// blanking and writes it into one bank of a double-buffered line buffer.
module display_line_fetch
  import display_pkg::*;
#(
  parameter int                ADDR_W    = 24,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                LB_ADDR_W = 9
) (
  input  logic                 clk_pix,
  input  logic                 rst,
  input  logic [11:0]          sx,
  input  logic [11:0]          sy,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_W-1:0]    mem_req_addr,
  input  logic                 mem_rd_valid,
  input  logic [DATA_W-1:0]    mem_rd_data,
  output logic                 lb_we,
  output logic                 lb_bank,
  output logic [LB_ADDR_W-1:0] lb_addr,
  output logic [DATA_W-1:0]    lb_data,
  output logic                 busy,
  output logic                 underrun
);

  localparam int LINE_WORDS = H_RES / PIX_PER_WORD;
  localparam int CNT_W      = LB_ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] line_base;
  logic              bank;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  dat_cnt;
  logic [11:0]       target;
  logic              target_ok;
  logic              trigger;
  logic              start;
  logic              req_fire;
  logic              data_beat;

  assign trigger = (sx == 12'(H_RES));

  // The last line of the frame wraps to line 0; lines past the active area fetch nothing.
  always_comb begin
    target    = '0;
    target_ok = 1'b0;
    if (sy == 12'(V_LAST)) begin
      target_ok = 1'b1;
    end else if (sy < 12'(V_RES - 1)) begin
      target    = sy + 12'd1;
      target_ok = 1'b1;
    end
  end

  assign start     = (state == IDLE) && trigger && target_ok;
  assign req_fire  = (state == REQ) && mem_req_ready;
  assign data_beat = (state != IDLE) && mem_rd_valid;

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    busy          = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = line_base + ADDR_W'(req_cnt);
        busy          = 1'b1;
        if (req_fire && (req_cnt == LAST_WORD)) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (data_beat && (dat_cnt == LAST_WORD)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Return data is in request order, so a running count is the line buffer address.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      line_base <= '0;
      bank      <= 1'b0;
      req_cnt   <= '0;
      dat_cnt   <= '0;
      lb_we     <= 1'b0;
      lb_bank   <= 1'b0;
      lb_addr   <= '0;
      lb_data   <= '0;
      underrun  <= 1'b0;
    end else begin
      lb_we    <= data_beat;
      underrun <= trigger && (state != IDLE);
      if (start) begin
        line_base <= BASE_ADDR + ADDR_W'(target) * ADDR_W'(LINE_WORDS);
        bank      <= target[0];
        req_cnt   <= '0;
        dat_cnt   <= '0;
      end
      if (req_fire) begin
        req_cnt <= req_cnt + CNT_W'(1);
      end
      if (data_beat) begin
        lb_bank <= bank;
        lb_addr <= dat_cnt[LB_ADDR_W-1:0];
        lb_data <= mem_rd_data;
        dat_cnt <= dat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_display_line_fetch.sv
// Scoreboard bench: a line-level reference model queues expected requests and
// line buffer writes; separate memory and monitor processes compare them.
module tb_display_line_fetch;
  import display_pkg::*;

  localparam int LINE_WORDS = H_RES / PIX_PER_WORD;

  typedef struct {
    logic        bank;
    logic [8:0]  addr;
    logic [31:0] data;
  } lb_item_t;

  logic        clk_pix = 1'b0;
  logic        rst;
  logic [11:0] sx, sy;
  logic        mem_req_valid, mem_req_ready;
  logic [23:0] mem_req_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        lb_we, lb_bank;
  logic [8:0]  lb_addr;
  logic [31:0] lb_data;
  logic        busy, underrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  int mode = 0;
  int accepted_cnt = 0;

  logic [23:0] req_exp_q[$];
  lb_item_t    lb_exp_q[$];
  int          underrun_exp_q[$];
  logic [23:0] infl_addr[$];
  int          infl_due[$];

  display_line_fetch dut (
    .clk_pix       (clk_pix),
    .rst           (rst),
    .sx            (sx),
    .sy            (sy),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rd_valid  (mem_rd_valid),
    .mem_rd_data   (mem_rd_data),
    .lb_we         (lb_we),
    .lb_bank       (lb_bank),
    .lb_addr       (lb_addr),
    .lb_data       (lb_data),
    .busy          (busy),
    .underrun      (underrun)
  );

  always #5 clk_pix = ~clk_pix;

  function automatic logic [31:0] memfn(input logic [23:0] a);
    return (32'(a) * 32'd2654435761) ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference model: one trigger either queues a whole line or flags an underrun.
  task automatic applyStimulus(input int y);
    int tgt;
    bit ok;
    logic [23:0] a;
    lb_item_t it;
    @(posedge clk_pix); #1;
    ok  = 1'b1;
    tgt = 0;
    if (y == V_LAST) tgt = 0;
    else if (y < V_RES - 1) tgt = y + 1;
    else ok = 1'b0;
    sx = 12'(H_RES);
    sy = 12'(y);
    if (lb_exp_q.size() != 0) begin
      underrun_exp_q.push_back(cyc + 1);
    end else if (ok) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        a = 24'(tgt * LINE_WORDS + i);
        req_exp_q.push_back(a);
        it.bank = tgt[0];
        it.addr = 9'(i);
        it.data = memfn(a);
        lb_exp_q.push_back(it);
      end
    end
    @(posedge clk_pix); #1;
    sx = '0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (lb_exp_q.size() != 0 && n < 8000) begin
      @(posedge clk_pix); #1;
      n++;
    end
    if (lb_exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got %0d writes outstanding, required 0", name, lb_exp_q.size());
      lb_exp_q.delete();
      req_exp_q.delete();
    end
    @(negedge clk_pix);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    checkOutput({name, "_req_left"}, 32'(req_exp_q.size()), 32'd0);
  endtask

  initial begin
    mem_req_ready = 1'b0;
    forever begin
      @(posedge clk_pix); #1;
      case (mode)
        0: mem_req_ready = 1'b1;
        1: mem_req_ready = ~mem_req_ready;
        2: mem_req_ready = ($urandom_range(0, 3) != 0);
        default: mem_req_ready = 1'b0;
      endcase
    end
  end

  // Memory model: checks requests, then returns data after lat cycles in order.
  initial begin
    logic        prev_stall;
    logic [23:0] prev_addr;
    logic [23:0] e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    forever begin
      @(negedge clk_pix);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          total++;
          if (!(mem_req_valid === 1'b1 && mem_req_addr === prev_addr)) begin
            bad++;
            $display("[TB] FAIL req_hold: got valid=%0d addr=%0d, required valid=1 addr=%0d",
                     mem_req_valid, mem_req_addr, prev_addr);
          end
        end
        if (mem_req_valid && mem_req_ready) begin
          total++;
          accepted_cnt++;
          if (req_exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL req_unexpected: got addr=%0d, required no request", mem_req_addr);
          end else begin
            e = req_exp_q.pop_front();
            if (mem_req_addr !== e) begin
              bad++;
              $display("[TB] FAIL req_addr: got %0d, required %0d", mem_req_addr, e);
            end
          end
        end
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr  = mem_req_addr;
      end
      if (mem_req_valid && mem_req_ready) begin
        infl_addr.push_back(mem_req_addr);
        infl_due.push_back(cyc + lat);
      end
      @(posedge clk_pix);
      cyc++;
      #1;
      if (infl_addr.size() != 0 && infl_due[0] <= cyc) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = memfn(infl_addr.pop_front());
        void'(infl_due.pop_front());
      end else begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = $urandom();
      end
    end
  end

  initial begin
    lb_item_t it;
    forever begin
      @(negedge clk_pix);
      if (lb_we) begin
        total++;
        if (lb_exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL lb_unexpected: got write bank=%0d addr=%0d, required no write", lb_bank, lb_addr);
        end else begin
          it = lb_exp_q.pop_front();
          if (lb_bank !== it.bank || lb_addr !== it.addr || lb_data !== it.data) begin
            bad++;
            $display("[TB] FAIL lb_write: got bank=%0d addr=%0d data=%h, required bank=%0d addr=%0d data=%h",
                     lb_bank, lb_addr, lb_data, it.bank, it.addr, it.data);
          end
        end
      end
      if (underrun) begin
        total++;
        if (underrun_exp_q.size() == 0 || underrun_exp_q[0] != cyc) begin
          bad++;
          $display("[TB] FAIL underrun_pulse: got pulse at cycle %0d, required %0d", cyc,
                   (underrun_exp_q.size() == 0) ? -1 : underrun_exp_q[0]);
        end
        if (underrun_exp_q.size() != 0) void'(underrun_exp_q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no finish, required finish within cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int y;
    rst = 1'b1;
    sx  = '0;
    sy  = '0;
    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix);
    checkOutput("rst_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("rst_req_addr", 32'(mem_req_addr), 32'd0);
    checkOutput("rst_lb_we", 32'(lb_we), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    @(posedge clk_pix); #1;
    rst = 1'b0;

    $display("[TB] line 5 from sy=4, ready high, latency 1");
    lat = 1; mode = 0;
    applyStimulus(4);
    @(negedge clk_pix);
    checkOutput("first_req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("first_req_addr", 32'(mem_req_addr), 32'd2400);
    waitIdle("line5");

    $display("[TB] frame wrap to line 0");
    applyStimulus(V_LAST);
    waitIdle("line0");

    $display("[TB] triggers outside the fetch window");
    applyStimulus(1079);
    repeat (4) begin
      @(negedge clk_pix);
      checkOutput("nofetch1079_busy", 32'(busy), 32'd0);
    end
    applyStimulus(1100);
    repeat (4) begin
      @(negedge clk_pix);
      checkOutput("nofetch1100_valid", 32'(mem_req_valid), 32'd0);
    end

    $display("[TB] toggling ready, latency 3");
    lat = 3; mode = 1;
    applyStimulus(20);
    waitIdle("toggle");

    $display("[TB] trigger while stalled");
    lat = 2; mode = 3;
    applyStimulus(30);
    repeat (10) @(posedge clk_pix);
    applyStimulus(31);
    repeat (3) @(posedge clk_pix);
    mode = 0;
    waitIdle("underrun");
    checkOutput("underrun_left", 32'(underrun_exp_q.size()), 32'd0);

    $display("[TB] reset after 100 requests");
    lat = 3; mode = 0;
    accepted_cnt = 0;
    applyStimulus(10);
    n = 0;
    while (accepted_cnt < 100 && n < 2000) begin
      @(posedge clk_pix); #1;
      n++;
    end
    checkOutput("reset_at_req", 32'(accepted_cnt), 32'd100);
    rst = 1'b1;
    @(posedge clk_pix); #1;
    rst = 1'b0;
    req_exp_q.delete();
    lb_exp_q.delete();
    underrun_exp_q.delete();
    @(negedge clk_pix);
    checkOutput("midrst_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("midrst_req_addr", 32'(mem_req_addr), 32'd0);
    checkOutput("midrst_lb_we", 32'(lb_we), 32'd0);
    checkOutput("midrst_lb_addr", 32'(lb_addr), 32'd0);
    checkOutput("midrst_lb_data", lb_data, 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    n = 0;
    while (infl_addr.size() != 0 && n < 100) begin
      @(posedge clk_pix); #1;
      n++;
    end
    repeat (5) @(posedge clk_pix);
    applyStimulus(10);
    waitIdle("after_reset");

    $display("[TB] randomized lines, ready and latency");
    for (int k = 0; k < 4; k++) begin
      lat  = $urandom_range(1, 4);
      mode = 2;
      y = ($urandom_range(0, 4) == 0) ? V_LAST : $urandom_range(0, V_RES - 2);
      applyStimulus(y);
      waitIdle("random");
      mode = 0;
      repeat (8) @(posedge clk_pix);
    end

    checkOutput("final_lb_left", 32'(lb_exp_q.size()), 32'd0);
    checkOutput("final_req_left", 32'(req_exp_q.size()), 32'd0);
    checkOutput("final_underrun_left", 32'(underrun_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
